// File: rtl/wam_pkg.sv
// Shared constants and helpers for the Whac-A-Mole mole generator.
package wam_pkg;

  localparam int unsigned WAM_N_HOLE    = 16;
  localparam int unsigned WAM_LIFE_W    = 4;
  localparam int unsigned WAM_RTO_W     = 8;
  localparam logic [15:0] WAM_LFSR_SEED = 16'hACE1;
  // Right-shift Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] WAM_LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? WAM_LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/wam_lfsr.sv
// Free-running 16-bit Galois LFSR; advances every clock, independent of game enable.
module wam_lfsr
  import wam_pkg::*;
#(
  parameter logic [15:0] SEED = WAM_LFSR_SEED
) (
  input  logic        clk,
  input  logic        clr_n,
  output logic [15:0] q
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) q <= SEED;
    else        q <= lfsr_next(q);
  end

endmodule

// File: rtl/wam_mole.sv
// Mole spawn / lifetime manager: spawns on ticks, ages live moles, classifies whacks.
module wam_mole
  import wam_pkg::*;
#(
  parameter int unsigned N_HOLE    = WAM_N_HOLE,
  parameter logic [15:0] LFSR_SEED = WAM_LFSR_SEED
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  en,
  input  logic                  tick,
  input  logic [WAM_LIFE_W-1:0] age,
  input  logic [WAM_RTO_W-1:0]  rto,
  input  logic [N_HOLE-1:0]     hit,
  output logic [N_HOLE-1:0]     mole,
  output logic                  hit_ok,
  output logic                  miss,
  output logic                  escape
);

  localparam int unsigned IDX_W = (N_HOLE > 1) ? $clog2(N_HOLE) : 1;

  logic [15:0]                              lfsr;
  logic [N_HOLE-1:0][WAM_LIFE_W-1:0]        life_all;
  logic [IDX_W-1:0]                         cand;
  logic [WAM_LIFE_W-1:0]                    spawn_life;
  logic                                     spawn;
  logic [N_HOLE-1:0]                        hit_live;
  logic [N_HOLE-1:0]                        hit_empty;
  logic [N_HOLE-1:0]                        expire;
  logic                                     unused_lfsr_bits;

  wam_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .clr_n (clr_n),
    .q     (lfsr)
  );

  // Candidate hole is the low bits of the top nibble, i.e. lfsr[15:12] mod N_HOLE.
  assign cand             = lfsr[12 +: IDX_W];
  assign spawn_life       = (age == '0) ? WAM_LIFE_W'(1) : age;
  assign spawn            = en && tick && (lfsr[WAM_RTO_W-1:0] < rto) && (life_all[cand] == '0);
  assign unused_lfsr_bits = ^{lfsr[15:12], lfsr[11:8]};

  for (genvar i = 0; i < N_HOLE; i++) begin : g_hole
    logic [WAM_LIFE_W-1:0] life;
    logic                  live;

    assign live         = (life != '0);
    assign life_all[i]  = life;
    assign mole[i]      = live;
    assign hit_live[i]  = en && hit[i] && live;
    assign hit_empty[i] = en && hit[i] && !live;
    // A whack on the expiring tick wins: the mole counts as hit, not escaped.
    assign expire[i]    = en && tick && !hit[i] && (life == WAM_LIFE_W'(1));

    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)                              life <= '0;
      else if (hit_live[i])                    life <= '0;
      else if (spawn && (cand == IDX_W'(i)))   life <= spawn_life;
      else if (en && tick && live)             life <= life - WAM_LIFE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hit_ok <= 1'b0;
      miss   <= 1'b0;
      escape <= 1'b0;
    end else begin
      hit_ok <= |hit_live;
      miss   <= |hit_empty;
      escape <= |expire;
    end
  end

endmodule
